// File: rtl/minmax_scan_ctrl.sv
// rtl/minmax_scan_ctrl.sv - scan sequencer feeding dual-bank word pairs into a min/max finder
module minmax_scan_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              fnd_clr,
    output logic              fnd_en,
    input  logic [DATA_W-1:0] fnd_max_i,
    input  logic [DATA_W-1:0] fnd_min_i,
    output logic              busy,
    output logic              done,
    output logic              empty,
    output logic [DATA_W-1:0] result_max,
    output logic [DATA_W-1:0] result_min
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_CAP   = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ZERO = '0;

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   cnt;
    logic              empty_r;
    logic              fnd_en_r;
    logic [DATA_W-1:0] max_r;
    logic [DATA_W-1:0] min_r;
    logic              cap_take;

    // Finder output is final during CAP, so results bypass the holding registers then.
    assign cap_take = (state == S_CAP) && !empty_r && !abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            base_r   <= '0;
            addr_r   <= '0;
            len_r    <= '0;
            cnt      <= '0;
            empty_r  <= 1'b0;
            fnd_en_r <= 1'b0;
            max_r    <= '0;
            min_r    <= '0;
        end else begin
            fnd_en_r <= (state == S_READ) && !abort;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (len != LEN_ZERO) begin
                            base_r  <= base_addr;
                            len_r   <= len;
                            empty_r <= 1'b0;
                            state   <= S_CLR;
                        end else begin
                            empty_r <= 1'b1;
                            state   <= S_CAP;
                        end
                    end
                end
                S_CLR: begin
                    cnt    <= '0;
                    addr_r <= base_r;
                    state  <= S_READ;
                end
                S_READ: begin
                    cnt    <= cnt + LEN_ONE;
                    addr_r <= addr_r + ADDR_ONE;
                    if (cnt == len_r - LEN_ONE) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    if (cap_take) begin
                        max_r <= fnd_max_i;
                        min_r <= fnd_min_i;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (abort && (state != S_IDLE)) begin
                state <= S_IDLE;
            end
        end
    end

    assign rd_en      = (state == S_READ);
    assign rd_addr    = addr_r;
    assign fnd_clr    = (state == S_CLR);
    assign fnd_en     = fnd_en_r;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_CAP) && !abort;
    assign empty      = done && empty_r;
    assign result_max = cap_take ? fnd_max_i : max_r;
    assign result_min = cap_take ? fnd_min_i : min_r;

endmodule

// File: tb/tb_minmax_scan_ctrl.sv
// tb/tb_minmax_scan_ctrl.sv - bench with memory/finder model and result scoreboard
module tb_minmax_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  base_in;
    logic [4:0]  len_in;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        fnd_clr;
    logic        fnd_en;
    logic [15:0] fnd_max;
    logic [15:0] fnd_min;
    logic        busy;
    logic        done;
    logic        empty;
    logic [15:0] result_max;
    logic [15:0] result_min;

    minmax_scan_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_in), .len(len_in), .rd_en(rd_en), .rd_addr(rd_addr),
        .fnd_clr(fnd_clr), .fnd_en(fnd_en), .fnd_max_i(fnd_max), .fnd_min_i(fnd_min),
        .busy(busy), .done(done), .empty(empty),
        .result_max(result_max), .result_min(result_min)
    );

    always #5 clk = ~clk;

    logic [15:0] mem_e [16];
    logic [15:0] mem_o [16];
    logic [15:0] ev_q, od_q;

    function automatic logic [15:0] max2(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction
    function automatic logic [15:0] min2(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

    // One-cycle-latency dual-bank memory followed by the min/max finder.
    always @(posedge clk) begin
        if (rd_en) begin
            ev_q <= mem_e[rd_addr];
            od_q <= mem_o[rd_addr];
        end
        if (fnd_clr) begin
            fnd_max <= 16'h0000;
            fnd_min <= 16'hFFFF;
        end else if (fnd_en) begin
            fnd_max <= max2(fnd_max, max2(ev_q, od_q));
            fnd_min <= min2(fnd_min, min2(ev_q, od_q));
        end
    end

    int         tests = 0;
    int         fails = 0;
    int         clr_cnt = 0;
    int         done_cnt = 0;
    logic [3:0] obs_addr [$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rd_en) obs_addr.push_back(rd_addr);
            if (fnd_clr) clr_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  base;
        logic [4:0]  len;
        logic [15:0] emax;
        logic [15:0] emin;
        logic        eempty;
    } vec_t;

    typedef struct {
        logic [15:0] mx;
        logic [15:0] mn;
        logic        em;
    } exp_t;

    exp_t        sb [$];
    vec_t        vecs [4];
    logic [15:0] last_mx, last_mn;

    function automatic void ref_scan(input logic [3:0] b, input logic [4:0] n,
                                     output logic [15:0] mx, output logic [15:0] mn);
        logic [3:0] a;
        mx = 16'h0000;
        mn = 16'hFFFF;
        for (int i = 0; i < int'(n); i++) begin
            a  = b + 4'(i);
            mx = max2(mx, max2(mem_e[a], mem_o[a]));
            mn = min2(mn, min2(mem_e[a], mem_o[a]));
        end
    endfunction

    task automatic run_scan(input logic [3:0] b, input logic [4:0] n, input logic [15:0] mx,
                            input logic [15:0] mn, input logic em, input bit poke);
        int   lat;
        int   clr0;
        bit   seen;
        exp_t x;
        logic [3:0] ea;
        x.mx = mx; x.mn = mn; x.em = em;
        sb.push_back(x);
        obs_addr.delete();
        clr0 = clr_cnt;
        @(negedge clk);
        base_in = b; len_in = n; start = 1'b1;
        lat = 0; seen = 1'b0;
        while (lat < 40 && !seen) begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (done) seen = 1'b1;
            else if (poke && (lat == 2 || lat == 4)) begin
                start = 1'b1; len_in = 5'd3; base_in = 4'd9;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), (n == 5'd0) ? 32'd1 : 32'(n) + 32'd3);
        if (seen && sb.size() > 0) begin
            x = sb.pop_front();
            chk("result_max", 32'(result_max), 32'(x.mx));
            chk("result_min", 32'(result_min), 32'(x.mn));
            chk("empty", 32'(empty), 32'(x.em));
        end
        chk("read_count", 32'(obs_addr.size()), 32'(n));
        for (int i = 0; i < obs_addr.size() && i < int'(n); i++) begin
            ea = b + 4'(i);
            chk("rd_addr", 32'(obs_addr[i]), 32'(ea));
        end
        chk("clr_count", 32'(clr_cnt - clr0), (n != 5'd0) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd0);
        chk("hold_max", 32'(result_max), 32'(mx));
        if (!em) begin
            last_mx = mx; last_mn = mn;
        end
    endtask

    int d0;

    initial begin
        for (int a = 0; a < 16; a++) begin
            mem_e[a] = 16'($urandom_range(16'h0100, 16'hFEFF));
            mem_o[a] = 16'($urandom_range(16'h0100, 16'hFEFF));
        end
        mem_e[0] = 16'd3; mem_e[1] = 16'd9; mem_e[2] = 16'd1; mem_e[3] = 16'd7;
        mem_o[0] = 16'd8; mem_o[1] = 16'd2; mem_o[2] = 16'd6; mem_o[3] = 16'd4;
        vecs[0] = '{base: 4'd0,  len: 5'd4,  emax: 16'd9, emin: 16'd1, eempty: 1'b0};
        vecs[1] = '{base: 4'd0,  len: 5'd0,  emax: 16'd9, emin: 16'd1, eempty: 1'b1};
        vecs[2] = '{base: 4'd14, len: 5'd4,  emax: 16'd0, emin: 16'd0, eempty: 1'b0};
        vecs[3] = '{base: 4'd7,  len: 5'd16, emax: 16'd0, emin: 16'd0, eempty: 1'b0};
        for (int i = 2; i < 4; i++) ref_scan(vecs[i].base, vecs[i].len, vecs[i].emax, vecs[i].emin);

        rst_n = 1'b0; start = 1'b1; abort = 1'b0; base_in = 4'd3; len_in = 5'd4;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_outputs", 32'({rd_en, fnd_clr, fnd_en, busy, done, empty}), 32'd0);
            chk("rst_addr", 32'(rd_addr), 32'd0);
            chk("rst_results", 32'({result_max, result_min}), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_scan(vecs[i].base, vecs[i].len, vecs[i].emax, vecs[i].emin, vecs[i].eempty, 1'b0);
        end

        // Abort on the second READ cycle of a len=8 scan.
        mem_e[5] = 16'hFFFF; mem_o[5] = 16'h0000;
        d0 = done_cnt;
        @(negedge clk);
        base_in = 4'd0; len_in = 5'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clr_state", 32'(fnd_clr), 32'd1);
        @(negedge clk);
        chk("read1_en", 32'(rd_en), 32'd1);
        @(negedge clk);
        chk("read2_addr", 32'(rd_addr), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 32'({busy, rd_en, fnd_en, fnd_clr}), 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_hold_max", 32'(result_max), 32'(last_mx));
        chk("abort_hold_min", 32'(result_min), 32'(last_mn));
        run_scan(4'd5, 5'd1, 16'hFFFF, 16'h0000, 1'b0, 1'b0);

        // Start pulses while busy are dropped.
        d0 = done_cnt;
        run_scan(4'd0, 5'd4, 16'd9, 16'd1, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("one_done_per_start", 32'(done_cnt - d0), 32'd1);
        chk("idle_after_pokes", 32'(busy), 32'd0);

        // start and abort together in IDLE.
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; abort = 1'b1; len_in = 5'd2; base_in = 4'd0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        chk("start_abort_no_done", 32'(done_cnt - d0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
